// File: rtl/axi_aw_pkg.sv
`default_nettype none
// ============================================================================
// Module   : axi_aw_pkg
// Brief    : Shared AXI write-address payload type and default field widths
//            for the AW arbiter/mux slice.
// Revision : 1.0 - initial release
// ============================================================================
package axi_aw_pkg;

    localparam int c_addr_w = 32;
    localparam int c_len_w  = 8;

    // One write-address beat as carried between requesters and the output
    typedef struct packed {
        logic [c_addr_w-1:0] addr;
        logic [c_len_w-1:0]  len;
        logic [2:0]          size;
        logic [1:0]          burst;
        logic [1:0]          lock;
        logic [3:0]          cache;
        logic [2:0]          prot;
        logic [3:0]          qos;
    } aw_payload_t;

endpackage : axi_aw_pkg
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rr_arbiter
// Brief    : Combinational round-robin picker. The search starts at i_ptr and
//            wraps; only requesters that are also set in i_prio are eligible.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     i_req,
    input  logic [IDX_W-1:0] i_ptr,
    input  logic [N-1:0]     i_prio,
    output logic [N-1:0]     o_grant,
    output logic [IDX_W-1:0] o_grant_idx
);

    logic [N-1:0] w_elig;
    logic         w_found;

    assign w_elig = i_req & i_prio;

    // First eligible index at or above ptr, otherwise first one below ptr
    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        w_found     = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!w_found && (j >= int'(i_ptr)) && w_elig[j]) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = IDX_W'(j);
                w_found     = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!w_found && (j < int'(i_ptr)) && w_elig[j]) begin
                o_grant[j]  = 1'b1;
                o_grant_idx = IDX_W'(j);
                w_found     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/aw_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : aw_arb_mux
// Brief    : N-to-1 AXI write-address arbiter and mux with a registered
//            output stage, round-robin fairness and slave-select decode.
//            Optional macro AW_ARB_MUX_QOS_EN: restrict arbitration to the
//            valid requesters carrying the highest qos value.
// Revision : 1.0 - initial release
// ============================================================================
module aw_arb_mux
    import axi_aw_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_W      = c_addr_w,
    parameter int LEN_W       = c_len_w,
    parameter int SEL_W       = 2
) (
    input  logic                             ACLK,
    input  logic                             ARESET,
    input  logic [NUM_MASTERS-1:0]           S_AWVALID,
    output logic [NUM_MASTERS-1:0]           S_AWREADY,
    input  aw_payload_t [NUM_MASTERS-1:0]    S_AW,
    output logic                             M_AWVALID,
    input  logic                             M_AWREADY,
    output aw_payload_t                      M_AW,
    output logic [$clog2(NUM_MASTERS)-1:0]   M_MASTER_ID,
    output logic [SEL_W-1:0]                 Selected_Slave
);

    localparam int c_idx_w = $clog2(NUM_MASTERS);
    // Lengths wider than the configured LEN_W are clipped on capture
    localparam logic [c_len_w-1:0] c_len_mask = c_len_w'((64'd1 << LEN_W) - 64'd1);

    logic [c_idx_w-1:0]     r_ptr;
    logic [NUM_MASTERS-1:0] w_prio;
    logic [NUM_MASTERS-1:0] w_grant;
    logic [c_idx_w-1:0]     w_win_idx;
    logic                   w_load;
    aw_payload_t            w_win;

`ifdef AW_ARB_MUX_QOS_EN
    logic [3:0] w_max_qos;

    // Only requesters at the highest qos present among valid ones may win
    always_comb begin
        w_max_qos = '0;
        w_prio    = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (S_AWVALID[i] && (S_AW[i].qos > w_max_qos)) begin
                w_max_qos = S_AW[i].qos;
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            w_prio[i] = (S_AW[i].qos == w_max_qos);
        end
    end
`else
    assign w_prio = '1;
`endif

    rr_arbiter #(
        .N     (NUM_MASTERS),
        .IDX_W (c_idx_w)
    ) u_arb (
        .i_req       (S_AWVALID),
        .i_ptr       (r_ptr),
        .i_prio      (w_prio),
        .o_grant     (w_grant),
        .o_grant_idx (w_win_idx)
    );

    // Accept a new beat whenever the output slot is free or draining
    assign w_load    = !ARESET && (!M_AWVALID || M_AWREADY) && (|S_AWVALID);
    assign S_AWREADY = w_load ? w_grant : '0;

    // Winning payload as it will be captured
    always_comb begin
        w_win     = S_AW[w_win_idx];
        w_win.len = w_win.len & c_len_mask;
    end

    // Output register stage and round-robin pointer
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            M_AWVALID      <= 1'b0;
            M_AW           <= '0;
            M_MASTER_ID    <= '0;
            Selected_Slave <= '0;
            r_ptr          <= '0;
        end else if (w_load) begin
            M_AWVALID      <= 1'b1;
            M_AW           <= w_win;
            M_MASTER_ID    <= w_win_idx;
            Selected_Slave <= w_win.addr[ADDR_W-1 -: SEL_W];
            r_ptr          <= (w_win_idx == c_idx_w'(NUM_MASTERS - 1)) ? '0
                                                                        : w_win_idx + c_idx_w'(1);
        end else if (M_AWREADY) begin
            M_AWVALID      <= 1'b0;
        end
    end

endmodule : aw_arb_mux
`default_nettype wire

// File: tb/tb_aw_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_aw_arb_mux
// Brief    : Self-checking bench for aw_arb_mux with a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_aw_arb_mux;
    import axi_aw_pkg::*;

    localparam int N = 4;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic [N-1:0]      S_AWVALID;
    logic [N-1:0]      S_AWREADY;
    aw_payload_t [N-1:0] S_AW;
    logic              M_AWVALID;
    logic              M_AWREADY;
    aw_payload_t       M_AW;
    logic [1:0]        M_MASTER_ID;
    logic [1:0]        Selected_Slave;

    always #5 ACLK = ~ACLK;

    aw_arb_mux #(
        .NUM_MASTERS (N),
        .ADDR_W      (32),
        .LEN_W       (8),
        .SEL_W       (2)
    ) dut (
        .ACLK           (ACLK),
        .ARESET         (ARESET),
        .S_AWVALID      (S_AWVALID),
        .S_AWREADY      (S_AWREADY),
        .S_AW           (S_AW),
        .M_AWVALID      (M_AWVALID),
        .M_AWREADY      (M_AWREADY),
        .M_AW           (M_AW),
        .M_MASTER_ID    (M_MASTER_ID),
        .Selected_Slave (Selected_Slave)
    );

    int n_checks = 0;
    int n_err    = 0;

    // Behavioural model state
    int          m_ptr = 0;
    bit          m_v   = 0;
    aw_payload_t m_aw  = '0;
    int          m_id  = 0;

    task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Winner by rule: scan from ptr modulo N, eligible = valid (and top qos)
    function automatic int pick();
        int best = -1;
        int maxq = -1;
        for (int j = 0; j < N; j++)
            if (S_AWVALID[j] && int'(S_AW[j].qos) > maxq) maxq = int'(S_AW[j].qos);
        for (int k = 0; k < N; k++) begin
            int  j;
            bit  ok;
            j  = (m_ptr + k) % N;
            ok = S_AWVALID[j];
`ifdef AW_ARB_MUX_QOS_EN
            ok = ok && (int'(S_AW[j].qos) == maxq);
`endif
            if (ok && best < 0) best = j;
        end
        return best;
    endfunction

    task automatic set_pl(int j, logic [31:0] a, logic [3:0] q);
        aw_payload_t p;
        p.addr  = a;
        p.len   = 8'($urandom);
        p.size  = 3'($urandom);
        p.burst = 2'($urandom);
        p.lock  = 2'($urandom);
        p.cache = 4'($urandom);
        p.prot  = 3'($urandom);
        p.qos   = q;
        S_AW[j] = p;
    endtask

    // One clock: compare DUT against model, then advance model at the edge
    task automatic cycle();
        int           w;
        bit           ld;
        logic [N-1:0] exp_rdy;
        #1;
        w  = pick();
        ld = !ARESET && (!m_v || M_AWREADY) && (w >= 0);
        exp_rdy = '0;
        if (ld) exp_rdy[w] = 1'b1;
        check("s_awready", 64'(S_AWREADY), 64'(exp_rdy));
        check("m_awvalid", 64'(M_AWVALID), 64'(m_v));
        check("m_aw", 64'(M_AW), 64'(m_aw));
        check("m_master_id", 64'(M_MASTER_ID), 64'(m_id));
        check("selected_slave", 64'(Selected_Slave), 64'(m_aw.addr[31:30]));
        @(posedge ACLK);
        if (ARESET) begin
            m_v = 0; m_aw = '0; m_id = 0; m_ptr = 0;
        end else if (ld) begin
            m_v = 1; m_aw = S_AW[w]; m_id = w; m_ptr = (w + 1) % N;
        end else if (M_AWREADY) begin
            m_v = 0;
        end
        @(negedge ACLK);
    endtask

    int seq[6] = '{0, 1, 2, 3, 0, 1};

    initial begin
        ARESET    = 1'b1;
        S_AWVALID = '1;
        M_AWREADY = 1'b1;
        for (int j = 0; j < N; j++) set_pl(j, $urandom, 4'd0);
        @(posedge ACLK);
        @(negedge ACLK);

        // Reset held with every requester valid
        repeat (3) begin
            cycle();
            check("rst_rdy", 64'(S_AWREADY), 64'd0);
            check("rst_vld", 64'(M_AWVALID), 64'd0);
        end
        ARESET = 1'b0;

        // Round-robin fairness, one beat per cycle
        for (int i = 0; i < 6; i++) begin
            cycle();
            check("rr_id", 64'(M_MASTER_ID), 64'(seq[i]));
            check("rr_vld", 64'(M_AWVALID), 64'd1);
        end

        // Drain, then stall master 1's beat
        S_AWVALID = '0;
        cycle();
        S_AWVALID = 4'b0010;
        set_pl(1, 32'h4000_0000, 4'd0);
        M_AWREADY = 1'b0;
        cycle();
        check("bp_id", 64'(M_MASTER_ID), 64'd1);
        S_AWVALID = '1;
        repeat (5) begin
            cycle();
            check("bp_rdy", 64'(S_AWREADY), 64'd0);
            check("bp_addr", 64'(M_AW.addr), 64'h4000_0000);
            check("bp_sel", 64'(Selected_Slave), 64'd1);
            check("bp_id_hold", 64'(M_MASTER_ID), 64'd1);
        end
        M_AWREADY = 1'b1;
        #1 check("rel_rdy", 64'(S_AWREADY), 64'b0100);
        cycle();
        check("rel_id", 64'(M_MASTER_ID), 64'd2);

        // Wrap from ptr=3 with only masters 3 and 0 requesting
        S_AWVALID = 4'b1001;
        cycle();
        check("wrap_id3", 64'(M_MASTER_ID), 64'd3);
        cycle();
        check("wrap_id0", 64'(M_MASTER_ID), 64'd0);

        // Reset while a beat is stalled on the output
        M_AWREADY = 1'b0;
        S_AWVALID = 4'b0010;
        cycle();
        check("mid_pre_vld", 64'(M_AWVALID), 64'd1);
        ARESET    = 1'b1;
        S_AWVALID = '1;
        #1 check("mid_rdy", 64'(S_AWREADY), 64'd0);
        cycle();
        check("mid_vld", 64'(M_AWVALID), 64'd0);
        ARESET = 1'b0;

        // qos: master 0 at 2, master 2 at 9, ptr back at 0
        S_AWVALID = 4'b0101;
        set_pl(0, $urandom, 4'd2);
        set_pl(2, $urandom, 4'd9);
        M_AWREADY = 1'b1;
        cycle();
`ifdef AW_ARB_MUX_QOS_EN
        check("qos_id", 64'(M_MASTER_ID), 64'd2);
`else
        check("qos_id", 64'(M_MASTER_ID), 64'd0);
`endif

        // Randomized traffic against the model
        for (int c = 0; c < 400; c++) begin
            ARESET    = ($urandom_range(99) == 0);
            S_AWVALID = N'($urandom);
            M_AWREADY = ($urandom_range(9) < 7);
            for (int j = 0; j < N; j++) set_pl(j, $urandom, 4'($urandom_range(3)));
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule : tb_aw_arb_mux
`default_nettype wire

// File: doc/aw_arb_mux.md
AW_ARB_MUX -- requirements
Module: aw_arb_mux

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4: number of write-address requesters, 2..8.
REQ-002 SHALL have parameter ADDR_W, default 32: AWADDR width.
REQ-003 SHALL have parameter LEN_W, default 8: AWLEN width.
REQ-004 SHALL have parameter SEL_W, default 2: Selected_Slave width, decoded from AWADDR[ADDR_W-1 -: SEL_W].
REQ-005 SHALL have port ACLK  in  1  clock, all logic on rising edge.
REQ-006 SHALL have port ARESET  in  1  reset, synchronous, active-high.
REQ-007 SHALL have port S_AWVALID  in  NUM_MASTERS  per-master request.
REQ-008 SHALL have port S_AWREADY  out  NUM_MASTERS  per-master accept.
REQ-009 SHALL have port S_AW  in  NUM_MASTERS x aw_payload_t  per-master addr/len/size/burst/lock/cache/prot/qos.
REQ-010 SHALL have port M_AWVALID  out  1  registered output valid.
REQ-011 SHALL have port M_AWREADY  in  1  downstream accept.
REQ-012 SHALL have port M_AW  out  aw_payload_t  registered winning payload.
REQ-013 SHALL have port M_MASTER_ID  out  $clog2(NUM_MASTERS)  index of the master that owns M_AW.
REQ-014 SHALL have port Selected_Slave  out  SEL_W  registered slave decode of M_AW.addr.

Function
REQ-015 Output register SHALL load when load = !M_AWVALID || M_AWREADY, and at least one S_AWVALID is high.
REQ-016 On load, exactly one S_AWREADY (the winner) SHALL be high, combinationally, in the same cycle. All others SHALL be low.
REQ-017 S_AWREADY SHALL be all-zero when load is false. No input is consumed while output is stalled.
REQ-018 Latency: a request accepted at edge N SHALL appear on M_AWVALID/M_AW from edge N onward.
REQ-019 Sustained throughput SHALL be one transfer per cycle when M_AWREADY stays high.
REQ-020 Arbitration SHALL be round-robin: the search starts at ptr; the first valid master at or after ptr, wrapping modulo NUM_MASTERS, wins.
REQ-021 ptr SHALL update to (winner+1) mod NUM_MASTERS on every load and hold otherwise. winner = NUM_MASTERS-1 SHALL wrap ptr to 0.
REQ-022 M_AWVALID SHALL clear after the M_AWVALID && M_AWREADY handshake when no new load occurs.
REQ-023 M_AW, M_MASTER_ID and Selected_Slave SHALL be stable while M_AWVALID && !M_AWREADY.
REQ-024 Selected_Slave SHALL equal winner addr[ADDR_W-1 -: SEL_W], captured with the payload.

Reset
REQ-025 While ARESET is high at a clock edge: M_AWVALID=0, M_AW=0, M_MASTER_ID=0, Selected_Slave=0, ptr=0.
REQ-026 S_AWREADY SHALL be 0 during reset.
REQ-027 Reset mid-transfer SHALL drop any held output beat without handshake. The first post-reset grant starts from master 0.

Configuration
REQ-028 With AW_ARB_MUX_QOS_EN defined: the winner SHALL be drawn from the valid masters with the highest qos, with round-robin from ptr among ties.
REQ-029 Without AW_ARB_MUX_QOS_EN: qos SHALL be ignored for arbitration and passed through unchanged.

Structure
REQ-030 Package axi_aw_pkg SHALL hold aw_payload_t (packed: addr, len, size[3], burst[2], lock[2], cache[4], prot[3], qos[4]) and the default ADDR_W/LEN_W constants.
REQ-031 Round-robin selection SHALL live in sub-module rr_arbiter (inputs req, ptr, optional prio mask; output one-hot grant plus index).

Verification
REQ-032 Bench SHALL cover reset: ARESET high 3 cycles with all S_AWVALID=1 -> S_AWREADY=0, M_AWVALID=0, and ptr=0 afterwards.
REQ-033 Bench SHALL cover round-robin fairness: 4 masters continuously valid, M_AWREADY=1 -> M_MASTER_ID sequence 0,1,2,3,0,1 with one beat per cycle.
REQ-034 Bench SHALL cover backpressure: M1 addr=0x4000_0000, M_AWREADY=0 for 5 cycles -> M_AW held, Selected_Slave=1, S_AWREADY=0 for all masters. Releasing ready -> the next winner loads in the same cycle.
REQ-035 Bench SHALL cover wrap: ptr=3 with only M3 and M0 valid -> M3 wins, ptr=0, then M0 wins.
REQ-036 Bench SHALL cover QoS (macro on): M0 qos=2 and M2 qos=9 both valid -> M2 wins. Macro off -> M0 wins from ptr=0.
REQ-037 Bench SHALL cover reset mid-beat: ARESET asserted while M_AWVALID=1 and M_AWREADY=0 -> M_AWVALID=0 the next edge, with no S_AWREADY pulse.
